mmu_feeder: RTL

- Upstream stage of the systolic matrix-multiply unit. Sequences one tile: weight-load phase, then activation streaming, then drain.
- Weight phase: drives the unit's control bit high and presents one weight row per beat.
- Activation phase: skews each activation row diagonally, so lane k reaches the array k cycles after lane 0, and pushes zeros to drain the array.
- Registered outputs connect directly to the matrix unit's control, data_arr and wt_arr inputs.

---
 rtl/mmu_pkg.sv | 16 +
 rtl/mmu_skew_line.sv | 39 +++
 rtl/mmu_feeder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mmu_pkg.sv
// Shared definitions for the matrix-unit feeder: tile sequencing states,
// default array geometry and the packed row width derived from it.
package mmu_pkg;

    localparam int DEPTH     = 4;
    localparam int BIT_WIDTH = 8;
    localparam int ROW_WIDTH = BIT_WIDTH * DEPTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_WT = 2'd1,
        STREAM  = 2'd2,
        FLUSH   = 2'd3
    } state_t;

endpackage

// File: rtl/mmu_skew_line.sv
// Diagonal skew line: lane k is delayed by k+1 register stages so that
// lane k of a row vector reaches the systolic array k cycles after lane 0.
// A synchronous clear empties every stage; the async reset does the same.
module mmu_skew_line #(
    parameter int depth     = 4,
    parameter int bit_width = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic [depth*bit_width-1:0]   din,
    output logic [depth*bit_width-1:0]   dout
);

    for (genvar k = 0; k < depth; k++) begin : g_lane
        logic [bit_width-1:0] stages [0:k];

        // Shift lane k one stage per cycle, or empty the lane on clear
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i <= k; i++) begin
                    stages[i] <= '0;
                end
            end else if (clear) begin
                for (int i = 0; i <= k; i++) begin
                    stages[i] <= '0;
                end
            end else begin
                stages[0] <= din[k*bit_width +: bit_width];
                for (int i = 1; i <= k; i++) begin
                    stages[i] <= stages[i-1];
                end
            end
        end

        assign dout[k*bit_width +: bit_width] = stages[k];
    end

endmodule

// File: rtl/mmu_feeder.sv
// Upstream sequencer for the systolic matrix-multiply unit. One tile is a
// weight-load phase (control high per accepted weight row), an activation
// stream through the diagonal skew line, and a zero-fill drain ending in a
// one-cycle done pulse.
// Optional build macro MMU_FEEDER_PERF_EN adds a saturating 16-bit count of
// STREAM cycles that carried no activation row (perf_bubbles).
module mmu_feeder
    import mmu_pkg::*;
#(
    parameter int depth     = DEPTH,
    parameter int bit_width = BIT_WIDTH,
    parameter int FLUSH_CYC = 2 * depth
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [bit_width*depth-1:0]   wt_row,
    input  logic                         wt_valid,
    output logic                         wt_ready,
    input  logic [bit_width*depth-1:0]   act_row,
    input  logic                         act_valid,
    input  logic                         act_last,
    output logic                         act_ready,
    output logic                         control,
    output logic [bit_width*depth-1:0]   wt_arr,
    output logic [bit_width*depth-1:0]   data_arr,
    output logic                         busy,
`ifdef MMU_FEEDER_PERF_EN
    output logic [15:0]                  perf_bubbles,
`endif
    output logic                         done
);

    localparam int ROW_W = bit_width * depth;
    localparam int CNT_W = $clog2(depth + 1);
    localparam int FL_W  = $clog2(FLUSH_CYC + 1);

    state_t             state;
    logic [CNT_W-1:0]   wt_cnt;
    logic [FL_W-1:0]    fl_cnt;
    logic               start_acc;
    logic               wt_xfer;
    logic               act_xfer;
    logic               wt_last;
    logic               flush_last;
    logic [ROW_W-1:0]   skew_in;

    assign start_acc  = (state == IDLE) && start;
    assign wt_xfer    = (state == LOAD_WT) && wt_valid;
    assign act_xfer   = (state == STREAM) && act_valid;
    assign wt_last    = (wt_cnt == CNT_W'(depth - 1));
    assign flush_last = (fl_cnt == FL_W'(FLUSH_CYC - 1));

    assign wt_ready  = (state == LOAD_WT);
    assign act_ready = (state == STREAM);
    assign busy      = (state != IDLE);
    assign done      = (state == FLUSH) && flush_last;

    // Bubbles and drain cycles push zeros into the skew line
    assign skew_in = act_xfer ? act_row : '0;

    // Tile sequencing: weight count, phase changes and drain length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            wt_cnt <= '0;
            fl_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= LOAD_WT;
                        wt_cnt <= '0;
                    end
                end
                LOAD_WT: begin
                    if (wt_valid) begin
                        wt_cnt <= wt_cnt + CNT_W'(1);
                        if (wt_last) begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (act_valid && act_last) begin
                        state  <= FLUSH;
                        fl_cnt <= '0;
                    end
                end
                FLUSH: begin
                    fl_cnt <= fl_cnt + FL_W'(1);
                    if (flush_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Weight shift strobe and row; a stalled beat presents zeros with no shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            control <= 1'b0;
            wt_arr  <= '0;
        end else begin
            control <= wt_xfer;
            wt_arr  <= wt_xfer ? wt_row : '0;
        end
    end

`ifdef MMU_FEEDER_PERF_EN
    // Saturating count of STREAM cycles without an activation transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_bubbles <= '0;
        end else if (start_acc) begin
            perf_bubbles <= '0;
        end else if ((state == STREAM) && !act_valid && (perf_bubbles != 16'hFFFF)) begin
            perf_bubbles <= perf_bubbles + 16'd1;
        end
    end
`endif

    mmu_skew_line #(
        .depth     (depth),
        .bit_width (bit_width)
    ) u_skew (
        .clk   (clk),
        .rst   (rst),
        .clear (start_acc),
        .din   (skew_in),
        .dout  (data_arr)
    );

endmodule
